// File: rtl/adc_pkg.sv
// adc_pkg: shared definitions for the LTC2308 device-side responder.
//   state_t        responder FSM states
//   CFG_*          bit positions inside the 6-bit config word {S/D,O/S,S1,S0,UNI,SLP}
//   BITS/CFG_BITS  result and config word widths
//   cfg_channel()  channel selected by a config word
//   code_sample()  picks and codes the sample for a config word
package adc_pkg;

  localparam int BITS     = 12;
  localparam int CFG_BITS = 6;
  localparam int CHANNELS = 8;

  localparam logic [CFG_BITS-1:0] RESET_CFG_DEFAULT = 6'h22;

  localparam int CFG_SD  = 5;
  localparam int CFG_OS  = 4;
  localparam int CFG_S1  = 3;
  localparam int CFG_S0  = 2;
  localparam int CFG_UNI = 1;
  localparam int CFG_SLP = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_READY   = 2'd2,
    ST_SHIFT   = 2'd3
  } state_t;

  // Differential mode returns the even channel of the pair, so O/S is
  // dropped instead of selecting polarity.
  function automatic logic [2:0] cfg_channel(input logic [CFG_BITS-1:0] cfg);
    logic [2:0] ch;
    ch = {cfg[CFG_S1], cfg[CFG_S0], cfg[CFG_SD] & cfg[CFG_OS]};
    return ch;
  endfunction

  // Bipolar coding flips the MSB: offset binary becomes two's complement.
  function automatic logic [BITS-1:0] code_sample(
    input logic [CHANNELS*BITS-1:0] chans,
    input logic [CFG_BITS-1:0]      cfg
  );
    logic [BITS-1:0] raw;
    raw = chans[int'(cfg_channel(cfg))*BITS +: BITS];
    if (!cfg[CFG_UNI]) raw = raw ^ 12'h800;
    return raw;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// sync_edge: multi-flop synchronizer for an asynchronous input followed by
// an edge detector on the synchronized level.
//   clk, rst    system clock, asynchronous active-high reset
//   async_in    raw input from another clock domain
//   level       synchronized level
//   rise, fall  1-clk pulses on synchronized rising / falling edges
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q[0] <= async_in;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/adc_ltc2308_responder.sv
// adc_ltc2308_responder: emulates the device end of an LTC2308 serial link.
// A CONVST rise latches one channel of chan_value (coded by cfg_word), a fixed
// conversion time follows, then the initiator clocks the 12-bit result out
// on SDO while shifting a 6-bit config word in on SDI for the next conversion.
//
// Handshake: there is no valid/ready pair; the link is paced by the
// initiator. SDI is taken on synchronized SCK rises, SDO advances on
// synchronized SCK falls, and frame_done marks the 12th fall.
//
// Ports:
//   clk, reset     system clock, asynchronous active-high reset
//   adc_convst     conversion start (async)
//   adc_sck        serial clock (async), period >= 8 clk
//   adc_sdi        config bit in, MSB first
//   adc_sdo        result bit out, MSB first
//   chan_value     eight 12-bit samples, ch n = [12n+11:12n]
//   busy           high while converting
//   frame_done     1-clk pulse at the end of a complete frame
//   cfg_word       config used by the conversion in progress / last done
//   fsm_state      current FSM state (debug)
module adc_ltc2308_responder
  import adc_pkg::*;
#(
  parameter int                  CONV_CYCLES = 80,
  parameter int                  SYNC_STAGES = 2,
  parameter logic [CFG_BITS-1:0] RESET_CFG   = RESET_CFG_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     adc_convst,
  input  logic                     adc_sck,
  input  logic                     adc_sdi,
  output logic                     adc_sdo,
  input  logic [CHANNELS*BITS-1:0] chan_value,
  output logic                     busy,
  output logic                     frame_done,
  output logic [CFG_BITS-1:0]      cfg_word,
  output state_t                   fsm_state
);

  localparam int CNT_W = $clog2(CONV_CYCLES + 1);

  // Synchronized inputs and edges
  logic convst_level, convst_rise, convst_fall;
  logic sck_level, sck_rise, sck_fall;
  logic sdi_level, sdi_rise, sdi_fall;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_convst (
    .clk      (clk),
    .rst      (reset),
    .async_in (adc_convst),
    .level    (convst_level),
    .rise     (convst_rise),
    .fall     (convst_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sck (
    .clk      (clk),
    .rst      (reset),
    .async_in (adc_sck),
    .level    (sck_level),
    .rise     (sck_rise),
    .fall     (sck_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sdi (
    .clk      (clk),
    .rst      (reset),
    .async_in (adc_sdi),
    .level    (sdi_level),
    .rise     (sdi_rise),
    .fall     (sdi_fall)
  );

  logic unused_edges;
  assign unused_edges = ^{convst_fall, sck_level, sdi_rise, sdi_fall};

  // State and datapath registers
  state_t              state, state_next;
  logic [CNT_W-1:0]    conv_cnt;
  logic [BITS-1:0]     data_sr;
  logic [CFG_BITS-1:0] cfg_shift;
  logic [2:0]          rise_cnt;
  logic [3:0]          fall_cnt;
  logic                sdo_q;

  // Control strobes decoded from state and synchronized edges
  logic start_conv, conv_done, capture, advance, last_fall, ready_drive;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Output / strobe decode. CONVST wins over any SCK edge in the same clk,
  // and is ignored only while a conversion is already running.
  always_comb begin
    start_conv  = convst_rise && (state != ST_CONVERT);
    conv_done   = (state == ST_CONVERT) && (conv_cnt == CNT_W'(CONV_CYCLES - 1));
    capture     = sck_rise && !convst_rise &&
                  ((state == ST_READY) ||
                   ((state == ST_SHIFT) && (rise_cnt < 3'(CFG_BITS))));
    advance     = sck_fall && !convst_rise && (state == ST_SHIFT);
    last_fall   = advance && (fall_cnt == 4'(BITS - 1));
    ready_drive = (state == ST_READY) && !convst_level;
    busy        = (state == ST_CONVERT);
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start_conv) state_next = ST_CONVERT;
      end
      ST_CONVERT: begin
        if (conv_done) state_next = ST_READY;
      end
      ST_READY: begin
        if (start_conv)    state_next = ST_CONVERT;
        else if (sck_rise) state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (start_conv)     state_next = ST_CONVERT;
        else if (last_fall) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath. A new conversion clears any partial config capture, so an
  // aborted frame never leaks bits into cfg_word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conv_cnt   <= '0;
      data_sr    <= '0;
      cfg_shift  <= '0;
      rise_cnt   <= '0;
      fall_cnt   <= '0;
      sdo_q      <= 1'b0;
      frame_done <= 1'b0;
      cfg_word   <= RESET_CFG;
    end else begin
      frame_done <= 1'b0;
      if (start_conv) begin
        data_sr   <= code_sample(chan_value, cfg_word);
        conv_cnt  <= '0;
        cfg_shift <= '0;
        rise_cnt  <= '0;
        fall_cnt  <= '0;
        sdo_q     <= 1'b0;
      end else begin
        if ((state == ST_CONVERT) && !conv_done) conv_cnt <= conv_cnt + 1'b1;

        if (capture) begin
          cfg_shift <= {cfg_shift[CFG_BITS-2:0], sdi_level};
          rise_cnt  <= rise_cnt + 1'b1;
        end

        if (last_fall) begin
          sdo_q      <= 1'b0;
          frame_done <= 1'b1;
          fall_cnt   <= '0;
          if (rise_cnt == 3'(CFG_BITS)) cfg_word <= cfg_shift;
        end else if (advance) begin
          sdo_q    <= data_sr[BITS-2];
          data_sr  <= {data_sr[BITS-2:0], 1'b0};
          fall_cnt <= fall_cnt + 1'b1;
        end else if (ready_drive) begin
          sdo_q <= data_sr[BITS-1];
        end
      end
    end
  end

  assign adc_sdo   = sdo_q;
  assign fsm_state = state;

endmodule

// File: tb/tb_adc_ltc2308_responder.sv
module tb_adc_ltc2308_responder;
  import adc_pkg::*;

  // Clock / reset
  logic        clk = 1'b0;
  logic        reset;
  logic        adc_convst, adc_sck, adc_sdi, adc_sdo;
  logic [95:0] chan_value;
  logic        busy, frame_done;
  logic [5:0]  cfg_word;
  state_t      fsm_state;

  always #5 clk = ~clk;

  adc_ltc2308_responder dut (
    .clk        (clk),
    .reset      (reset),
    .adc_convst (adc_convst),
    .adc_sck    (adc_sck),
    .adc_sdi    (adc_sdi),
    .adc_sdo    (adc_sdo),
    .chan_value (chan_value),
    .busy       (busy),
    .frame_done (frame_done),
    .cfg_word   (cfg_word),
    .fsm_state  (fsm_state)
  );

  // Scoreboard
  int          checks   = 0;
  int          failures = 0;
  int          fd_cnt   = 0;
  logic [11:0] exp_q[$];
  logic        rd_bits[0:15];
  logic [5:0]  model_cfg;

  always @(negedge clk) if (frame_done === 1'b1) fd_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: pick the channel from the config fields and apply the
  // coding by adding half scale modulo 4096.
  function automatic logic [11:0] ref_sample(input logic [95:0] chans, input logic [5:0] cfg);
    int ch;
    int val;
    ch = cfg[3] * 4 + cfg[2] * 2 + (cfg[5] ? int'(cfg[4]) : 0);
    val = int'(chans[ch*12 +: 12]);
    if (!cfg[1]) val = (val + 2048) % 4096;
    return val[11:0];
  endfunction

  // Driver tasks
  task automatic do_convert(input bit toggle, output int busy_len);
    bit seen;
    bit done;
    busy_len = 0;
    seen = 0;
    done = 0;
    @(negedge clk);
    adc_convst = 1'b1;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      if (k == 3) adc_convst = 1'b0;
      if (toggle) adc_sck = (k >= 8 && k < 64) ? ((k / 8) % 2 == 1) : 1'b0;
      if (busy === 1'b1) begin
        busy_len++;
        seen = 1;
      end else if (seen) begin
        done = 1;
      end
    end
    adc_convst = 1'b0;
    adc_sck = 1'b0;
    check("conv_timeout", done, 1);
    repeat (4) @(negedge clk);
  endtask

  task automatic do_frame(input int n_sck, input logic [5:0] word, output logic [11:0] data);
    for (int i = 0; i < n_sck; i++) begin
      @(negedge clk);
      rd_bits[i] = adc_sdo;
      adc_sdi = (i < 6) ? word[5-i] : 1'b0;
      adc_sck = 1'b1;
      repeat (8) @(negedge clk);
      adc_sck = 1'b0;
      repeat (7) @(negedge clk);
    end
    repeat (8) @(negedge clk);
    for (int i = 0; i < 12; i++) data[11-i] = rd_bits[i];
  endtask

  task automatic convert_expect(input bit toggle, input string tag);
    int len;
    exp_q.push_back(ref_sample(chan_value, model_cfg));
    do_convert(toggle, len);
    check({tag, "_busy_len"}, len, 80);
  endtask

  task automatic frame_expect(input string tag, input logic [5:0] word, input int n_sck,
                              output logic [11:0] data);
    logic [11:0] exp;
    do_frame(n_sck, word, data);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hxxx;
    check({tag, "_sdo"}, data, exp);
    model_cfg = word;
    check({tag, "_cfg"}, cfg_word, model_cfg);
  endtask

  initial begin
    logic [11:0] d;
    logic [5:0]  w;
    int          fd0;
    int          len;

    reset = 1'b1;
    adc_convst = 1'b0;
    adc_sck = 1'b0;
    adc_sdi = 1'b0;
    chan_value = {$urandom, $urandom, $urandom};
    chan_value[11:0] = 12'hABC;
    model_cfg = 6'h22;
    repeat (3) @(negedge clk);
    check("rst_sdo", adc_sdo, 0);
    check("rst_busy", busy, 0);
    check("rst_fd", frame_done, 0);
    check("rst_cfg", cfg_word, 6'h22);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Basic frame on ch0
    fd0 = fd_cnt;
    convert_expect(0, "t1");
    frame_expect("t1", 6'h22, 12, d);
    check("t1_abc", d, 12'hABC);
    check("t1_fd_once", fd_cnt - fd0, 1);

    // Select single-ended ch2 ({S1,S0,O/S} = 010), read it next frame
    convert_expect(0, "t2a");
    frame_expect("t2a", 6'h26, 12, d);
    convert_expect(0, "t2b");
    frame_expect("t2b", 6'h22, 12, d);
    check("t2_ch2", d, chan_value[35:24]);

    // Bipolar ch0 at both ends of the range
    convert_expect(0, "t3a");
    frame_expect("t3a", 6'h20, 12, d);
    chan_value[11:0] = 12'h000;
    convert_expect(0, "t3b");
    frame_expect("t3b", 6'h20, 12, d);
    check("t3_zero", d, 12'h800);
    chan_value[11:0] = 12'hFFF;
    convert_expect(0, "t3c");
    frame_expect("t3c", 6'h22, 12, d);
    check("t3_full", d, 12'h7FF);

    // SCK toggling during conversion is ignored
    convert_expect(1, "t4");
    frame_expect("t4", 6'h22, 12, d);
    check("t4_ch0", d, 12'hFFF);

    // Abort after 3 SCKs
    convert_expect(0, "t5a");
    fd0 = fd_cnt;
    do_frame(3, 6'h3F, d);
    void'(exp_q.pop_front());
    convert_expect(0, "t5b");
    check("t5_no_fd", fd_cnt - fd0, 0);
    check("t5_cfg_kept", cfg_word, 6'h22);
    frame_expect("t5b", 6'h22, 12, d);
    check("t5_fd", fd_cnt - fd0, 1);

    // 14 SCKs: tail bits read zero
    convert_expect(0, "t6");
    frame_expect("t6", 6'h22, 14, d);
    check("t6_bit13", rd_bits[12], 0);
    check("t6_bit14", rd_bits[13], 0);
    check("t6_sdo_idle", adc_sdo, 0);

    // Randomized frames; chan_value changes after CONVST must not matter
    for (int n = 0; n < 6; n++) begin
      chan_value = {$urandom, $urandom, $urandom};
      convert_expect(0, "rnd");
      chan_value = {$urandom, $urandom, $urandom};
      w = 6'($urandom_range(0, 63));
      frame_expect("rnd", w, 12, d);
    end

    // Reset in the middle of a shift
    convert_expect(0, "t7a");
    frame_expect("t7a", 6'h3C, 12, d);
    convert_expect(0, "t7b");
    do_frame(5, 6'h11, d);
    void'(exp_q.pop_front());
    reset = 1'b1;
    #1;
    check("t7_sdo", adc_sdo, 0);
    check("t7_busy", busy, 0);
    check("t7_cfg", cfg_word, 6'h22);
    check("t7_state", fsm_state, ST_IDLE);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("exp_q_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
